// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types and constants for the UART receive controller, its FIFO and receiver core.
package uart_rx_ctrl_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } ctrl_state_e;

    typedef enum logic [2:0] {
        C_IDLE   = 3'd0,
        C_START  = 3'd1,
        C_DATA   = 3'd2,
        C_STOP   = 3'd3,
        C_WAITHI = 3'd4
    } core_state_e;

endpackage

// File: rtl/UartRxEn.sv
// Oversampling 8N1 receiver core; advances only on en_i ticks, reports each frame with done_o (+err_o on bad stop).
module UartRxEn
    import uart_rx_ctrl_pkg::*;
#(
    parameter int Oversample = 16
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              en_i,
    input  logic              rx_i,
    output logic [DATA_W-1:0] data_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int CntW = $clog2(Oversample);

    core_state_e       st_q;
    logic [CntW-1:0]   cnt_q;
    logic [2:0]        bit_idx_q;
    logic [DATA_W-1:0] shift_q;
    logic              done_q;
    logic              err_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            st_q      <= C_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (en_i) begin
                unique case (st_q)
                    C_IDLE: begin
                        if (!rx_i) begin
                            st_q  <= C_START;
                            cnt_q <= '0;
                        end
                    end
                    // Re-check the start bit at its midpoint to reject glitches.
                    C_START: begin
                        if (cnt_q == CntW'(Oversample / 2 - 1)) begin
                            cnt_q     <= '0;
                            bit_idx_q <= '0;
                            st_q      <= rx_i ? C_IDLE : C_DATA;
                        end else begin
                            cnt_q <= cnt_q + CntW'(1);
                        end
                    end
                    C_DATA: begin
                        if (cnt_q == CntW'(Oversample - 1)) begin
                            cnt_q   <= '0;
                            shift_q <= {rx_i, shift_q[DATA_W-1:1]};
                            if (bit_idx_q == 3'd7) begin
                                st_q <= C_STOP;
                            end else begin
                                bit_idx_q <= bit_idx_q + 3'd1;
                            end
                        end else begin
                            cnt_q <= cnt_q + CntW'(1);
                        end
                    end
                    C_STOP: begin
                        if (cnt_q == CntW'(Oversample - 1)) begin
                            cnt_q  <= '0;
                            done_q <= 1'b1;
                            err_q  <= !rx_i;
                            st_q   <= rx_i ? C_IDLE : C_WAITHI;
                        end else begin
                            cnt_q <= cnt_q + CntW'(1);
                        end
                    end
                    // A low stop bit may be a break; wait for the line to return high.
                    C_WAITHI: begin
                        if (rx_i) begin
                            st_q <= C_IDLE;
                        end
                    end
                    default: st_q <= C_IDLE;
                endcase
            end
        end
    end

    assign data_o = shift_q;
    assign done_o = done_q;
    assign err_o  = err_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO; reports a dropped push when full without a simultaneous pop.
module uart_rx_fifo
    import uart_rx_ctrl_pkg::*;
#(
    parameter int Depth = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic [DATA_W-1:0]            push_data_i,
    input  logic                         pop_i,
    output logic [DATA_W-1:0]            data_o,
    output logic                         valid_o,
    output logic [$clog2(Depth+1)-1:0]   count_o,
    output logic                         drop_o
);

    localparam int PtrW = $clog2(Depth);
    localparam int CntW = $clog2(Depth + 1);

    logic [DATA_W-1:0] mem_q [Depth];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              empty, full, do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CntW'(Depth));
    assign do_pop  = pop_i && !empty;
    // When full, a same-cycle pop frees the slot the write lands in.
    assign do_push = push_i && (!full || do_pop);
    assign drop_o  = push_i && full && !do_pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CntW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign data_o  = empty ? '0 : mem_q[rd_ptr_q];
    assign valid_o = !empty;
    assign count_o = count_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: baud tick generator, OFF/ARMED/RUN sequencing, receiver core wrapper and
// buffered output with sticky overrun/frame-error flags. The serial line is assumed already synchronous to clk.
module uart_rx_ctrl
    import uart_rx_ctrl_pkg::*;
#(
    parameter int Oversample = 16,
    parameter int FifoDepth  = 4,
    parameter int DivWidth   = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic [DivWidth-1:0]              divisor,
    input  logic                             in,
    output logic [DATA_W-1:0]                data,
    output logic                             valid,
    input  logic                             ready,
    output logic [$clog2(FifoDepth+1)-1:0]   count,
    output logic                             overrun,
    output logic                             frameErr,
    input  logic                             clearErr
);

    localparam int IdleW = $clog2(Oversample + 1);

    ctrl_state_e       state_q;
    logic [IdleW-1:0]  idle_cnt_q;
    logic              core_rstn_q;
    logic [DivWidth-1:0] tick_cnt_q, tick_cnt_d;
    logic              tick;
    logic              core_en, core_done, core_err;
    logic [DATA_W-1:0] core_data;
    logic              push_pending_q, push_pending_d;
    logic [DATA_W-1:0] push_data_q, push_data_d;
    logic              overrun_q, overrun_d;
    logic              frame_err_q, frame_err_d;
    logic              fifo_drop;

    // Core reset is registered alongside the state so it is low exactly while state_q is OFF.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= OFF;
            idle_cnt_q  <= '0;
            core_rstn_q <= 1'b0;
        end else if (!enable) begin
            state_q     <= OFF;
            idle_cnt_q  <= '0;
            core_rstn_q <= 1'b0;
        end else begin
            unique case (state_q)
                OFF: begin
                    state_q     <= ARMED;
                    idle_cnt_q  <= '0;
                    core_rstn_q <= 1'b1;
                end
                ARMED: begin
                    if (tick) begin
                        if (!in) begin
                            idle_cnt_q <= '0;
                        end else if (idle_cnt_q == IdleW'(Oversample - 1)) begin
                            state_q    <= RUN;
                            idle_cnt_q <= '0;
                        end else begin
                            idle_cnt_q <= idle_cnt_q + IdleW'(1);
                        end
                    end
                end
                RUN: begin
                end
                default: state_q <= OFF;
            endcase
        end
    end

    assign tick    = (state_q != OFF) && (tick_cnt_q == '0);
    assign core_en = tick && (state_q == RUN);

    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if (state_q == OFF || tick_cnt_q == '0) begin
            tick_cnt_d = divisor;
        end else begin
            tick_cnt_d = tick_cnt_q - DivWidth'(1);
        end

        push_pending_d = core_done && !core_err;
        push_data_d    = core_done ? core_data : push_data_q;

        // Set events win over a coincident clear.
        overrun_d   = fifo_drop ? 1'b1 : (clearErr ? 1'b0 : overrun_q);
        frame_err_d = core_err  ? 1'b1 : (clearErr ? 1'b0 : frame_err_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_q     <= '0;
            push_pending_q <= 1'b0;
            overrun_q      <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            tick_cnt_q     <= tick_cnt_d;
            push_pending_q <= push_pending_d;
            overrun_q      <= overrun_d;
            frame_err_q    <= frame_err_d;
        end
    end

    always_ff @(posedge clk) begin
        push_data_q <= push_data_d;
    end

    UartRxEn #(
        .Oversample (Oversample)
    ) u_core (
        .clk_i  (clk),
        .rstn_i (core_rstn_q),
        .en_i   (core_en),
        .rx_i   (in),
        .data_o (core_data),
        .done_o (core_done),
        .err_o  (core_err)
    );

    uart_rx_fifo #(
        .Depth (FifoDepth)
    ) u_fifo (
        .clk_i       (clk),
        .rst_i       (reset),
        .push_i      (push_pending_q),
        .push_data_i (push_data_q),
        .pop_i       (ready),
        .data_o      (data),
        .valid_o     (valid),
        .count_o     (count),
        .drop_o      (fifo_drop)
    );

    assign overrun  = overrun_q;
    assign frameErr = frame_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a byte-queue reference model checked every settled cycle.
module tb_uart_rx_ctrl;
    import uart_rx_ctrl_pkg::*;

    localparam int DEPTH = 4;

    logic        clk, reset, enable, in, ready, clearErr;
    logic [15:0] divisor;
    logic [7:0]  data;
    logic        valid, overrun, frameErr;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_mis = 0;
    bit settled = 0;
    logic [7:0] mq[$];
    bit m_ovr = 0;
    bit m_ferr = 0;

    uart_rx_ctrl #(
        .Oversample (16),
        .FifoDepth  (DEPTH),
        .DivWidth   (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .divisor  (divisor),
        .in       (in),
        .data     (data),
        .valid    (valid),
        .ready    (ready),
        .count    (count),
        .overrun  (overrun),
        .frameErr (frameErr),
        .clearErr (clearErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: outputs follow directly from the queue of accepted bytes and the sticky flags.
    always @(negedge clk) begin
        logic [31:0] hd;
        if (settled) begin
            hd = (mq.size() != 0) ? {24'd0, mq[0]} : 32'd0;
            cmp("m_valid",    {31'd0, valid},    {31'd0, mq.size() != 0});
            cmp("m_count",    {29'd0, count},    mq.size());
            cmp("m_data",     {24'd0, data},     hd);
            cmp("m_overrun",  {31'd0, overrun},  {31'd0, m_ovr});
            cmp("m_frameErr", {31'd0, frameErr}, {31'd0, m_ferr});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int bp);
        in = 1'b0;
        cyc(bp);
        for (int i = 0; i < 8; i++) begin
            in = b[i];
            cyc(bp);
        end
        in = stop_ok;
        cyc(bp);
        in = 1'b1;
    endtask

    task automatic rx_byte(input logic [7:0] b, input bit ok, input int bp);
        settled = 0;
        send_frame(b, ok, bp);
        cyc(bp);
        if (!ok) m_ferr = 1;
        else if (mq.size() < DEPTH) mq.push_back(b);
        else m_ovr = 1;
        settled = 1;
    endtask

    task automatic pop_expect(input logic [7:0] e);
        cmp("pop_data", {24'd0, data}, {24'd0, e});
        ready = 1'b1;
        cyc(1);
        ready = 1'b0;
        void'(mq.pop_front());
    endtask

    task automatic clear_err();
        clearErr = 1'b1;
        cyc(1);
        clearErr = 1'b0;
        m_ovr  = 0;
        m_ferr = 0;
    endtask

    // Raises ready or clearErr for exactly the cycle in which the pending byte is written.
    task automatic pulse_on_push(input bit use_clear);
        bit seen;
        seen = 0;
        for (int i = 0; i < 4000 && !seen; i++) begin
            cyc(1);
            if (dut.push_pending_q) begin
                seen = 1;
                if (use_clear) clearErr = 1'b1;
                else ready = 1'b1;
                cyc(1);
                clearErr = 1'b0;
                ready    = 1'b0;
            end
        end
        cmp("push_seen", {31'd0, seen}, 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; enable = 1'b0; in = 1'b1; divisor = 16'd3;
        ready = 1'b0; clearErr = 1'b0;
        cyc(3);
        cmp("rst_valid",    {31'd0, valid},    32'd0);
        cmp("rst_count",    {29'd0, count},    32'd0);
        cmp("rst_data",     {24'd0, data},     32'd0);
        cmp("rst_overrun",  {31'd0, overrun},  32'd0);
        cmp("rst_frameErr", {31'd0, frameErr}, 32'd0);
        reset = 1'b0;
        cyc(2);
        settled = 1;

        // Line low at enable: held in ARMED, then RUN on the 16th idle tick (ticks every 4 clk).
        in = 1'b0;
        enable = 1'b1;
        cyc(1);
        cyc(40);
        cmp("armed_line_low", 32'(dut.state_q), 32'(ARMED));
        in = 1'b1;
        cyc(63);
        cmp("armed_tick15", 32'(dut.state_q), 32'(ARMED));
        cyc(1);
        cmp("run_tick16", 32'(dut.state_q), 32'(RUN));
        cyc(20);

        // Single byte 0xA5 with a 64-clk bit period.
        rx_byte(8'hA5, 1, 64);
        cmp("a5_valid", {31'd0, valid}, 32'd1);
        cmp("a5_data",  {24'd0, data},  32'hA5);
        cmp("a5_count", {29'd0, count}, 32'd1);
        pop_expect(8'hA5);
        cmp("a5_count_after_pop", {29'd0, count}, 32'd0);

        // Five bytes without draining: fifth dropped.
        for (int b = 1; b <= 5; b++) rx_byte(8'(b), 1, 64);
        cmp("ovf_count",   {29'd0, count},   32'd4);
        cmp("ovf_overrun", {31'd0, overrun}, 32'd1);
        for (int b = 1; b <= 4; b++) pop_expect(8'(b));

        // Bad stop bit flags frameErr without a push.
        clear_err();
        cmp("clr_overrun", {31'd0, overrun}, 32'd0);
        rx_byte(8'h11, 1, 64);
        rx_byte(8'h3C, 0, 64);
        cmp("ferr_set",   {31'd0, frameErr}, 32'd1);
        cmp("ferr_count", {29'd0, count},    32'd1);
        clear_err();
        cmp("ferr_clr", {31'd0, frameErr}, 32'd0);
        pop_expect(8'h11);

        // Disable midway through data bit 3, re-enable, then a clean 0x5A.
        in = 1'b0;
        cyc(64 * 4 + 32);
        enable = 1'b0;
        in = 1'b1;
        cyc(20);
        enable = 1'b1;
        cyc(200);
        rx_byte(8'h5A, 1, 64);
        cmp("reen_count",    {29'd0, count},    32'd1);
        cmp("reen_data",     {24'd0, data},     32'h5A);
        cmp("reen_overrun",  {31'd0, overrun},  32'd0);
        cmp("reen_frameErr", {31'd0, frameErr}, 32'd0);
        pop_expect(8'h5A);

        // Full FIFO: push with coincident pop, then push with coincident clearErr.
        for (int b = 0; b < 4; b++) rx_byte(8'h10 + 8'(b), 1, 64);
        cmp("full_count",   {29'd0, count},   32'd4);
        cmp("full_overrun", {31'd0, overrun}, 32'd0);
        settled = 0;
        fork
            send_frame(8'h14, 1, 64);
            pulse_on_push(0);
        join
        cyc(64);
        void'(mq.pop_front());
        mq.push_back(8'h14);
        settled = 1;
        cmp("pp_count",   {29'd0, count},   32'd4);
        cmp("pp_overrun", {31'd0, overrun}, 32'd0);
        cmp("pp_head",    {24'd0, data},    32'h11);
        settled = 0;
        fork
            send_frame(8'h15, 1, 64);
            pulse_on_push(1);
        join
        cyc(64);
        m_ovr = 1;
        settled = 1;
        cmp("clr_vs_set_overrun", {31'd0, overrun}, 32'd1);
        cmp("clr_vs_set_count",   {29'd0, count},   32'd4);
        for (int b = 1; b <= 4; b++) pop_expect(8'h10 + 8'(b));
        clear_err();

        // divisor=0: one tick per clk, 16-clk bits.
        divisor = 16'd0;
        cyc(20);
        rx_byte(8'hC3, 1, 16);
        cmp("div0_data",  {24'd0, data},  32'hC3);
        cmp("div0_count", {29'd0, count}, 32'd1);
        rx_byte(8'h81, 0, 16);
        cmp("div0_ferr", {31'd0, frameErr}, 32'd1);

        // Reset mid-frame discards everything.
        settled = 0;
        in = 1'b0;
        cyc(64);
        reset = 1'b1;
        cyc(3);
        in = 1'b1;
        reset = 1'b0;
        mq.delete();
        m_ovr  = 0;
        m_ferr = 0;
        cyc(2);
        settled = 1;
        cmp("mid_rst_count",    {29'd0, count},    32'd0);
        cmp("mid_rst_valid",    {31'd0, valid},    32'd0);
        cmp("mid_rst_data",     {24'd0, data},     32'd0);
        cmp("mid_rst_frameErr", {31'd0, frameErr}, 32'd0);
        cyc(50);
        settled = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter Oversample, default 16: ticks per bit, passed to the receiver core.
REQ-002 SHALL have parameter FifoDepth, default 4: receive FIFO entries; must be a power of two and at least 2.
REQ-003 SHALL have parameter DivWidth, default 16: width of the baud divisor.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; every flop is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset is asynchronous and active-high.
REQ-006 SHALL have port enable, input, 1 bit: receiver run request.
REQ-007 SHALL have port divisor, input, DivWidth bits: tick period minus one, in clk cycles.
REQ-008 SHALL have port in, input, 1 bit: serial line; idles high.
REQ-009 SHALL have port data, output, 8 bits: FIFO head byte.
REQ-010 SHALL have port valid, output, 1 bit: FIFO not empty.
REQ-011 SHALL have port ready, input, 1 bit: consumer accepts the head.
REQ-012 SHALL have port count, output, $clog2(FifoDepth+1) bits: current FIFO occupancy.
REQ-013 SHALL have port overrun, output, 1 bit: sticky flag, a byte was dropped.
REQ-014 SHALL have port frameErr, output, 1 bit: sticky flag, the receiver core reported an error.
REQ-015 SHALL have port clearErr, input, 1 bit: clears both sticky flags.

Function
REQ-016 SHALL implement a controller FSM with states OFF, ARMED and RUN.
REQ-017 OFF -> ARMED when enable=1.
REQ-018 ARMED -> RUN after Oversample consecutive ticks with in=1; any tick with in=0 restarts that count.
REQ-019 Any state -> OFF when enable=0; this takes priority over every other transition.
REQ-020 Tick generator: a down-counter loads divisor, decrements each cycle in ARMED/RUN and emits tick for one cycle at 0, then reloads.
REQ-021 divisor=0 SHALL give a tick every cycle.
REQ-022 A divisor change SHALL take effect only at the next reload.
REQ-023 In OFF, the tick counter SHALL hold divisor and tick SHALL be 0.
REQ-024 Receiver core en SHALL equal tick AND (state==RUN).
REQ-025 Receiver core active-low reset SHALL be driven by a register that is low while reset=1 or state==OFF; the core restarts clean after any disable.
REQ-026 On core done=1 with err=0, the controller SHALL set pushPending, then write the core's data byte into the FIFO on the next clk.
REQ-027 On core err=1, frameErr SHALL be set and nothing is pushed for that frame.
REQ-028 The FIFO SHALL be first-word-fall-through: data = head entry, valid = (count != 0).
REQ-029 A pop SHALL occur on valid && ready; a pop when empty is impossible because valid is low.
REQ-030 A push with count==FifoDepth and no simultaneous pop SHALL drop the byte and set overrun.
REQ-031 A push and pop in the same cycle when full SHALL keep count unchanged, store the byte and leave overrun unchanged.
REQ-032 Pointers SHALL be $clog2(FifoDepth) bits wide and wrap modulo FifoDepth; count SHALL saturate within 0..FifoDepth.
REQ-033 clearErr SHALL clear overrun and frameErr on the next edge; a set event in the same cycle SHALL win and the flag stays 1.
REQ-034 Disabling SHALL NOT flush the FIFO; buffered bytes stay poppable while in OFF.
REQ-035 A pushPending outstanding at disable SHALL still complete.

Reset
REQ-036 On reset: state=OFF, tick counter=0, pushPending=0, FIFO pointers=0, count=0, valid=0, data=0, overrun=0, frameErr=0.
REQ-037 Reset asserted mid-frame SHALL discard the partial frame and all FIFO contents.

Structure
REQ-038 A shared package SHALL hold the controller state enum {OFF, ARMED, RUN} and the 8-bit data-width constant.
REQ-039 The receiver core SHALL be instantiated once as UartRxEn, with Oversample passed through.
REQ-040 The FIFO SHALL be a sub-module named uart_rx_fifo.

Verification
REQ-041 Scenario: divisor=3, enable=1, line idle for 16 ticks, then send 0xA5 8N1 with a 64-clk bit period -> valid=1, data=0xA5, count=1 after the stop bit; ready=1 -> count=0.
REQ-042 Scenario: ready=0, send 5 bytes 0x01..0x05 -> count=4, overrun=1, pops return 0x01..0x04 in order.
REQ-043 Scenario: send 0x3C with the stop bit driven low -> frameErr=1, count unchanged; clearErr pulse -> frameErr=0.
REQ-044 Scenario: enable=0 midway through bit 3 of a frame, re-enable, send 0x5A -> exactly one byte 0x5A received, no error flags.
REQ-045 Scenario: in=0 at enable rise -> state stays ARMED; line released high -> RUN after exactly 16 ticks.
REQ-046 Scenario: FIFO full, push and pop in the same cycle -> count=4, overrun=0; clearErr coincident with an overrun -> overrun=1.
